// File: rtl/hd_add8_pkg.sv
// Shared defaults and FSM state type for the framed mod-2^WIDTH accumulator.
package hd_add8_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/add8_mod256.sv
// Purely combinational modular adder: y = (a + b) mod 2^WIDTH. Holds no state.
module add8_mod256 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Truncating add; the carry-out is dropped by the WIDTH-bit result.
    assign y = a + b;

endmodule

// File: rtl/hd_add8_frame_accum.sv
// Framed byte-stream front end for the mod-2^WIDTH adder. Accumulates the
// beats of each frame through add8_mod256 and presents one registered frame
// sum and saturating beat count per frame over a valid/ready handshake.
// Optional feature macro: HD_ADD8_OVF_CNT_EN adds a per-frame saturating
// wrap counter driven on out_ovf.
module hd_add8_frame_accum
    import hd_add8_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
`ifdef HD_ADD8_OVF_CNT_EN
    output logic [CNT_W-1:0] out_ovf,
`endif
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic [WIDTH-1:0] sum_w;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat;

    add8_mod256 #(.WIDTH(WIDTH)) u_add (
        .a (acc_q),
        .b (in_data),
        .y (sum_w)
    );

    // Ready depends only on state (and is held low while in reset).
    assign in_ready  = !rst && (state_q != OUT);
    assign beat      = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: a frame closes only on an accepted beat carrying in_last.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACC: if (beat) state_d = in_last ? OUT : ACC;
            OUT:       if (out_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Accumulator and result registers; the running sum is cleared as the
    // result is captured so IDLE always starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_count_q <= '0;
        end else if (beat) begin
            if (in_last) begin
                out_sum_q   <= sum_w;
                out_count_q <= cnt_inc;
                acc_q       <= '0;
                cnt_q       <= '0;
            end else begin
                acc_q <= sum_w;
                cnt_q <= cnt_inc;
            end
        end
    end

`ifdef HD_ADD8_OVF_CNT_EN
    logic             carry_w;
    logic [CNT_W-1:0] ovf_q;
    logic [CNT_W-1:0] ovf_inc;
    logic [CNT_W-1:0] out_ovf_q;

    // A modular sum smaller than the accumulator operand means the add wrapped.
    assign carry_w = (sum_w < acc_q);
    assign ovf_inc = (carry_w && (ovf_q != CNT_MAX)) ? ovf_q + 1'b1 : ovf_q;
    assign out_ovf = out_ovf_q;

    // Per-frame wrap counter, captured alongside the frame sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q     <= '0;
            out_ovf_q <= '0;
        end else if (beat) begin
            if (in_last) begin
                out_ovf_q <= ovf_inc;
                ovf_q     <= '0;
            end else begin
                ovf_q <= ovf_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hd_add8_frame_accum.sv
// Directed bench for hd_add8_frame_accum: a default instance and a CNT_W=2
// instance share one stimulus stream; expected values are hand-computed.
module tb_hd_add8_frame_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready, out_valid;
    logic [7:0] out_sum, out_count;
    logic       in_ready_s, out_valid_s;
    logic [7:0] out_sum_s;
    logic [1:0] out_count_s;
`ifdef HD_ADD8_OVF_CNT_EN
    logic [7:0] out_ovf;
    logic [1:0] out_ovf_s;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hd_add8_frame_accum u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
`ifdef HD_ADD8_OVF_CNT_EN
        .out_ovf   (out_ovf),
`endif
        .out_count (out_count)
    );

    hd_add8_frame_accum #(.WIDTH(8), .CNT_W(2)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_sum   (out_sum_s),
`ifdef HD_ADD8_OVF_CNT_EN
        .out_ovf   (out_ovf_s),
`endif
        .out_count (out_count_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one beat at the falling edge; it is taken on the next rising edge.
    task automatic send_beat(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    // Accept the pending result in one cycle.
    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Reset state
        check("rst_in_ready",  in_ready,  0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum",   out_sum,   0);
        check("rst_out_count", out_count, 0);
`ifdef HD_ADD8_OVF_CNT_EN
        check("rst_out_ovf",   out_ovf,   0);
`endif
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_ready, 1);

        // Frame 0x10,0x20,0x30
        send_beat(8'h10, 1'b0);
        check("f1_mid_valid", out_valid, 0);
        send_beat(8'h20, 1'b0);
        send_beat(8'h30, 1'b1);
        check("f1_out_valid", out_valid, 1);
        check("f1_out_sum",   out_sum,   8'h60);
        check("f1_out_count", out_count, 3);
        check("f1_in_ready",  in_ready,  0);
        consume();
        check("f1_done_valid", out_valid, 0);
        check("f1_done_ready", in_ready,  1);

        // Frame 0xFF,0x02 wraps once
        send_beat(8'hFF, 1'b0);
        send_beat(8'h02, 1'b1);
        check("f2_out_sum",   out_sum,   8'h01);
        check("f2_out_count", out_count, 2);
`ifdef HD_ADD8_OVF_CNT_EN
        check("f2_out_ovf",   out_ovf,   1);
`endif
        consume();

        // Single-beat frame, then hold the result for 5 cycles
        send_beat(8'hA5, 1'b1);
        check("f3_out_valid", out_valid, 1);
        check("f3_out_sum",   out_sum,   8'hA5);
        check("f3_out_count", out_count, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_sum",   out_sum,   8'hA5);
            check("hold_out_count", out_count, 1);
            check("hold_in_ready",  in_ready,  0);
        end
        consume();
        check("f3_done_valid", out_valid, 0);
        check("f3_done_ready", in_ready,  1);

        // Reset mid-frame discards the partial sum
        send_beat(8'h40, 1'b0);
        send_beat(8'h50, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_idle_ready", in_ready, 1);
        send_beat(8'h07, 1'b1);
        check("f4_out_valid", out_valid, 1);
        check("f4_out_sum",   out_sum,   8'h07);
        check("f4_out_count", out_count, 1);
        consume();

        // Five beats of 0x01: the CNT_W=2 instance saturates at 3
        for (int i = 0; i < 4; i++) send_beat(8'h01, 1'b0);
        send_beat(8'h01, 1'b1);
        check("f5_out_sum",     out_sum,     8'h05);
        check("f5_out_count",   out_count,   5);
        check("f5_sat_valid",   out_valid_s, 1);
        check("f5_sat_sum",     out_sum_s,   8'h05);
        check("f5_sat_count",   out_count_s, 3);
`ifdef HD_ADD8_OVF_CNT_EN
        check("f5_out_ovf",     out_ovf,     0);
`endif
        consume();
        check("f5_sat_done",    out_valid_s, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
